output_writer: RTL
==================

OUTPUT_WRITER -- requirements
Module: output_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter DATA_LENGTH_WIDTH, default 20, width of the packet byte-length field.
REQ-003 SHALL have parameter RAM_ADDR_WIDTH, default 10, buffer depth of 2^RAM_ADDR_WIDTH beats.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have ports s_tdata, s_tvalid, s_tkeep, s_tlast: inputs of width DATA_WIDTH, 1, DATA_WIDTH/8 and 1, carrying the AXI-stream packet from the link side.
REQ-007 SHALL have port s_tready, output, 1, stream-side ready.
REQ-008 SHALL have port data_ready_out, output, 1, high while a complete packet is buffered and waiting.
REQ-009 SHALL have port fetch_data_in, input, 1, user request to start unloading the buffered packet.
REQ-010 SHALL have port data_ready_in, input, 1, user-side backpressure.
REQ-011 SHALL have ports data_out, data_valid_out, data_first_out, data_keep_out, data_last_out and data_len_out: outputs of width DATA_WIDTH, 1, 1, DATA_WIDTH/8, 1 and DATA_LENGTH_WIDTH, forming the user-side packet stream.
REQ-012 SHALL have port ack_o, output, 1, one-cycle pulse when the packet is fully unloaded.
REQ-013 SHALL have port overflow_o, output, 1, sticky flag set when a packet exceeds buffer depth.

Function
REQ-014 SHALL implement states IDLE, RECV, HOLD and SEND.
REQ-015 SHALL drive s_tready=1 in IDLE and RECV, and s_tready=0 in HOLD and SEND.
REQ-016 SHALL write each accepted beat (s_tvalid&s_tready) to RAM at the incrementing write address starting at 0, together with its tkeep.
REQ-017 SHALL move from IDLE to RECV on the first accepted beat with s_tlast=0.
REQ-018 SHALL move from IDLE or RECV to HOLD on an accepted beat with s_tlast=1; a single-beat packet goes IDLE->HOLD directly.
REQ-019 SHALL accumulate byte count as the sum of popcount(s_tkeep) over accepted beats, and present data_len_out = count-1, held constant from HOLD entry until return to IDLE.
REQ-020 SHALL assert data_ready_out in the cycle after the tlast beat is accepted, holding it until the cycle fetch_data_in is sampled high in HOLD.
REQ-021 SHALL ignore fetch_data_in outside HOLD.
REQ-022 SHALL move from HOLD to SEND when fetch_data_in=1, with RAM read latency 1, and present the first beat with data_valid_out=1 no later than 2 cycles after fetch is sampled.
REQ-023 SHALL transfer an output beat only on data_valid_out&data_ready_in, holding data_out, data_keep_out, data_first_out and data_last_out stable while data_ready_in=0.
REQ-024 SHALL sustain 1 beat/cycle with data_ready_in held high.
REQ-025 SHALL use internal output buffering so that an arbitrary data_ready_in pattern never drops or duplicates a beat.
REQ-026 SHALL assert data_first_out on the first beat of the packet only, and data_last_out on beat index (beat count-1) only; both may coincide.
REQ-027 SHALL, on the cycle after the last-beat handshake, return to IDLE, pulse ack_o for exactly 1 cycle, and clear the read/write addresses and byte count.
REQ-028 SHALL, when an accepted beat would exceed 2^RAM_ADDR_WIDTH, not write it, set overflow_o, keep accepting until tlast, and then treat the packet as length 2^RAM_ADDR_WIDTH beats.
REQ-029 SHALL keep overflow_o set until reset.
REQ-030 SHALL ignore beats with s_tvalid=0 and perform no state change on them.

Reset
REQ-031 SHALL, on reset_n=0 asynchronously, force state IDLE, addresses and counters 0, s_tready=0, data_ready_out=0, data_valid_out=0, data_first_out=0, data_last_out=0, data_out=0, data_keep_out=0, data_len_out=0, ack_o=0 and overflow_o=0.
REQ-032 SHALL drive s_tready=1 from the first clock edge after reset_n deasserts.
REQ-033 SHALL discard a packet in progress (RECV/HOLD/SEND) when reset asserts, with no ack_o.

Verification
REQ-034 SHALL be verified with 33 beats (first tkeep 0xF0, rest 0xFF) sent then fetched with data_ready_in=1 -> data_len_out=259, 33 consecutive beats, first/last flags correct, ack_o one pulse.
REQ-035 SHALL be verified with a single beat with tlast and tkeep 0xFF -> data_len_out=7, and data_first_out and data_last_out both asserted on the one beat.
REQ-036 SHALL be verified with data_ready_in toggling low for 1 cycle every 6, 4 and 9 beats during SEND -> output sequence identical to input with no gaps or repeats.
REQ-037 SHALL be verified with a second packet offered while in HOLD -> s_tready=0 and no RAM write; the packet is accepted after ack_o.
REQ-038 SHALL be verified with 1025 beats at RAM_ADDR_WIDTH=10 -> overflow_o=1 and exactly 1024 beats unloaded.
REQ-039 SHALL be verified with reset_n pulsed low mid-SEND -> all outputs return to reset values immediately and the next packet is handled normally.

Source files
------------

// File: rtl/output_writer.sv
// Packet buffer: stores one AXI-stream packet in block RAM, then replays it
// on the user side on request, with a two-entry skid stage for backpressure.
`timescale 1ns/1ps
module output_writer #(
    parameter int DATA_WIDTH        = 64,
    parameter int DATA_LENGTH_WIDTH = 20,
    parameter int RAM_ADDR_WIDTH    = 10
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [DATA_WIDTH-1:0]        s_tdata,
    input  logic                         s_tvalid,
    input  logic [DATA_WIDTH/8-1:0]      s_tkeep,
    input  logic                         s_tlast,
    output logic                         s_tready,
    output logic                         data_ready_out,
    input  logic                         fetch_data_in,
    input  logic                         data_ready_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         data_valid_out,
    output logic                         data_first_out,
    output logic [DATA_WIDTH/8-1:0]      data_keep_out,
    output logic                         data_last_out,
    output logic [DATA_LENGTH_WIDTH-1:0] data_len_out,
    output logic                         ack_o,
    output logic                         overflow_o
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int CW     = RAM_ADDR_WIDTH + 1;
    localparam int DEPTH  = 1 << RAM_ADDR_WIDTH;
    localparam int MW     = DATA_WIDTH + KEEP_W;
    localparam int BW     = MW + 2;
    localparam logic [CW-1:0]                CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [DATA_LENGTH_WIDTH-1:0] LEN_ONE = {{(DATA_LENGTH_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RECV, HOLD, SEND} state_t;

    state_t                       state_q, state_d;
    logic                         s_tready_q, s_tready_d;
    logic [CW-1:0]                wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [DATA_LENGTH_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
    logic [DATA_LENGTH_WIDTH-1:0] len_q, len_d;
    logic                         data_ready_q, data_ready_d;
    logic                         ack_q, ack_d;
    logic                         overflow_q, overflow_d;
    logic                         rd_vld_q, rd_vld_d;
    logic                         rd_first_q, rd_first_d;
    logic                         rd_last_q, rd_last_d;
    logic                         out_vld_q, out_vld_d;
    logic [BW-1:0]                out_beat_q, out_beat_d;
    logic                         skid_vld_q, skid_vld_d;
    logic [BW-1:0]                skid_beat_q, skid_beat_d;

    logic [MW-1:0]                mem [DEPTH];
    logic [MW-1:0]                rd_word_q;

    logic                         accept, full, wr_en, rd_en, pop;
    logic [1:0]                   occ;
    logic [DATA_LENGTH_WIDTH-1:0] keep_bytes;
    logic [BW-1:0]                in_beat;

    assign accept  = s_tvalid & s_tready_q;
    assign full    = wr_cnt_q[RAM_ADDR_WIDTH];
    assign wr_en   = accept & ~full;
    assign pop     = out_vld_q & data_ready_in;
    assign in_beat = {rd_first_q, rd_last_q, rd_word_q};

    // Beats held or in flight after this cycle; a new read is issued only if it will have a slot.
    assign occ   = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, rd_vld_q} - {1'b0, pop};
    assign rd_en = ((state_q == SEND) || ((state_q == HOLD) && fetch_data_in))
                   && (rd_ptr_q != wr_cnt_q) && (occ < 2'd2);

    always_comb begin
        keep_bytes = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            keep_bytes = keep_bytes + {{(DATA_LENGTH_WIDTH-1){1'b0}}, s_tkeep[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_cnt_q[RAM_ADDR_WIDTH-1:0]] <= {s_tkeep, s_tdata};
        end
        if (rd_en) begin
            rd_word_q <= mem[rd_ptr_q[RAM_ADDR_WIDTH-1:0]];
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_ptr_d     = rd_en ? rd_ptr_q + CNT_ONE : rd_ptr_q;
        byte_cnt_d   = byte_cnt_q;
        len_d        = len_q;
        data_ready_d = data_ready_q;
        ack_d        = 1'b0;
        overflow_d   = overflow_q;
        rd_vld_d     = rd_en;
        rd_first_d   = (rd_ptr_q == '0);
        rd_last_d    = (rd_ptr_q == wr_cnt_q - CNT_ONE);

        if (accept) begin
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                wr_cnt_d   = wr_cnt_q + CNT_ONE;
                byte_cnt_d = byte_cnt_q + keep_bytes;
            end
            if (s_tlast) begin
                state_d      = HOLD;
                data_ready_d = 1'b1;
                len_d        = byte_cnt_d - LEN_ONE;
            end else begin
                state_d = RECV;
            end
        end

        case (state_q)
            HOLD: begin
                if (fetch_data_in) begin
                    state_d      = SEND;
                    data_ready_d = 1'b0;
                end
            end
            SEND: begin
                if (pop && out_beat_q[MW]) begin
                    state_d    = IDLE;
                    ack_d      = 1'b1;
                    wr_cnt_d   = '0;
                    rd_ptr_d   = '0;
                    byte_cnt_d = '0;
                end
            end
            default: ;
        endcase

        s_tready_d = (state_d == IDLE) || (state_d == RECV);
    end

    // Output register plus one skid entry absorbs the beat already in flight from RAM.
    always_comb begin
        out_vld_d   = out_vld_q;
        out_beat_d  = out_beat_q;
        skid_vld_d  = skid_vld_q;
        skid_beat_d = skid_beat_q;
        if (!out_vld_q || pop) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_beat_d = skid_beat_q;
                skid_vld_d = rd_vld_q;
                if (rd_vld_q) begin
                    skid_beat_d = in_beat;
                end
            end else begin
                out_vld_d = rd_vld_q;
                if (rd_vld_q) begin
                    out_beat_d = in_beat;
                end
            end
        end else if (rd_vld_q) begin
            skid_vld_d  = 1'b1;
            skid_beat_d = in_beat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            s_tready_q   <= 1'b0;
            wr_cnt_q     <= '0;
            rd_ptr_q     <= '0;
            byte_cnt_q   <= '0;
            len_q        <= '0;
            data_ready_q <= 1'b0;
            ack_q        <= 1'b0;
            overflow_q   <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_first_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            out_vld_q    <= 1'b0;
            out_beat_q   <= '0;
            skid_vld_q   <= 1'b0;
            skid_beat_q  <= '0;
        end else begin
            state_q      <= state_d;
            s_tready_q   <= s_tready_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            byte_cnt_q   <= byte_cnt_d;
            len_q        <= len_d;
            data_ready_q <= data_ready_d;
            ack_q        <= ack_d;
            overflow_q   <= overflow_d;
            rd_vld_q     <= rd_vld_d;
            rd_first_q   <= rd_first_d;
            rd_last_q    <= rd_last_d;
            out_vld_q    <= out_vld_d;
            out_beat_q   <= out_beat_d;
            skid_vld_q   <= skid_vld_d;
            skid_beat_q  <= skid_beat_d;
        end
    end

    assign s_tready       = s_tready_q;
    assign data_ready_out = data_ready_q;
    assign data_out       = out_beat_q[DATA_WIDTH-1:0];
    assign data_keep_out  = out_beat_q[MW-1:DATA_WIDTH];
    assign data_last_out  = out_vld_q & out_beat_q[MW];
    assign data_first_out = out_vld_q & out_beat_q[MW+1];
    assign data_valid_out = out_vld_q;
    assign data_len_out   = len_q;
    assign ack_o          = ack_q;
    assign overflow_o     = overflow_q;

endmodule
